bcd_convert_ctrl: RTL

BCD_CONVERT_CTRL -- requirements
Module: bcd_convert_ctrl

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bcd_convert_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W     = 4;
  localparam int ADD3_THRESH = 4;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble cell: add 3 to a BCD digit above the threshold
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  always_comb begin
    q = d;
    if (d > DIGIT_W'(ADD3_THRESH)) q = d + DIGIT_W'(3);
  end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// rtl/bcd_convert_ctrl.sv - sequential signed/unsigned binary-to-BCD converter
// One operand bit is shifted into the BCD register per cycle (double dabble).
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int N      = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                is_signed,
  input  logic [N-1:0]        A,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] BCD,
  output logic                neg,
  output logic [DIGITS-1:0]   blank
);

  localparam int              BW        = DIGIT_W * DIGITS;
  localparam int              CW        = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(N);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t          state, state_nxt;
  logic [N-1:0]    mag, mag_nxt, mag_load;
  logic [BW-1:0]   sh, adj, sh_nxt;
  logic [BW+N-1:0] shifted;
  logic [CW-1:0]   cnt;
  logic            neg_pend, neg_load;
  logic            accept, last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d(sh[g*DIGIT_W +: DIGIT_W]),
      .q(adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // blank[k] is set while digit k and everything above it are zero; digit 0 always shows
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] v);
    logic [DIGITS-1:0] m;
    logic              z;
    m = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z    = z & (v[k*DIGIT_W +: DIGIT_W] == '0);
      m[k] = z;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  always_comb begin
    shifted = {adj, mag} << 1;
    sh_nxt  = shifted[BW+N-1:N];
    mag_nxt = shifted[N-1:0];
  end

  // Negating -2^(N-1) wraps to 2^(N-1), which is the correct unsigned magnitude
  assign neg_load = is_signed & A[N-1];
  assign mag_load = neg_load ? (~A + N'(1)) : A;
  assign accept   = ready & start;
  assign last     = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      SHIFT:   busy  = 1'b1;
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag      <= '0;
      sh       <= '0;
      cnt      <= '0;
      neg_pend <= 1'b0;
      BCD      <= '0;
      neg      <= 1'b0;
      blank    <= BLANK_RST;
    end else if (accept) begin
      mag      <= mag_load;
      sh       <= '0;
      cnt      <= CNT_LOAD;
      neg_pend <= neg_load;
    end else if (state == SHIFT) begin
      mag <= mag_nxt;
      sh  <= sh_nxt;
      cnt <= cnt - CW'(1);
      if (last) begin
        BCD   <= sh_nxt;
        neg   <= neg_pend & (|sh_nxt);
        blank <= blank_mask(sh_nxt);
      end
    end
  end

endmodule
